// File: rtl/sigmf_bwd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sigmf_bwd : sigmoid backward pass, o = g * s * (1 - s), signed Q8.24,
//             iterative shift-add multiplier with valid/ready on both sides.
// Revision  : 1.0
// ============================================================================
module sigmf_bwd #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] act,
  input  logic [WIDTH-1:0] grad,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1) << FRAC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_mag_g;
  logic               r_sgn;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_o;

  logic               w_act_neg;
  logic               w_act_big;
  logic [WIDTH-1:0]   w_sa;
  logic [WIDTH-1:0]   w_ca;
  logic [WIDTH-1:0]   w_mag_g;
  logic [2*WIDTH-1:0] w_add;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res;
  logic               w_last;

  // Clamp s into [0, 1.0] so s*(1-s) stays within [0, 0.25].
  assign w_act_neg = act[WIDTH-1];
  assign w_act_big = !w_act_neg && (act > c_one);
  assign w_sa      = w_act_neg ? '0 : (w_act_big ? c_one : act);
  assign w_ca      = c_one - w_sa;
  assign w_mag_g   = grad[WIDTH-1] ? (-grad) : grad;

  assign w_add  = r_mplier[0] ? r_mcand : '0;
  assign w_prod = r_acc + w_add;
  assign w_res  = w_prod[FRAC +: WIDTH];
  assign w_last = (r_cnt == CW'(WIDTH-1));

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign o         = r_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (in_valid) w_state_nxt = MUL1;
      MUL1: if (w_last)   w_state_nxt = MUL2;
      MUL2: if (w_last)   w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_mag_g  <= '0;
      r_sgn    <= 1'b0;
      r_cnt    <= '0;
      r_o      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_sa};
            r_mplier <= w_ca;
            r_mag_g  <= w_mag_g;
            r_sgn    <= grad[WIDTH-1];
            r_cnt    <= '0;
          end
        end
        MUL1, MUL2: begin
          r_acc    <= w_prod;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_acc <= '0;
            r_cnt <= '0;
            // First pass yields d, which becomes the multiplicand against |g|.
            if (r_state == MUL1) begin
              r_mcand  <= {{WIDTH{1'b0}}, w_res};
              r_mplier <= r_mag_g;
            end else begin
              r_o <= r_sgn ? (-w_res) : w_res;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sigmf_bwd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_sigmf_bwd : self-checking bench for sigmf_bwd against an arithmetic model.
// Revision     : 1.0
// ============================================================================
module tb_sigmf_bwd;

  localparam int W    = 32;
  localparam int F    = 24;
  localparam int LAT  = 2*W + 1;
  localparam longint ONE = 64'd1 << F;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] act;
  logic [W-1:0] grad;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] o;

  int n_cmp;
  int n_err;

  sigmf_bwd #(.WIDTH(W), .FRAC(F)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act       (act),
    .grad      (grad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_o(input logic [31:0] a, input logic [31:0] g);
    longint s, d, mg, m;
    s = longint'($signed(a));
    if (s < 0)   s = 0;
    if (s > ONE) s = ONE;
    d  = (s * (ONE - s)) / ONE;
    mg = longint'($signed(g));
    if (mg < 0) mg = -mg;
    m  = (d * mg) / ONE;
    return g[31] ? 32'(-m) : 32'(m);
  endfunction

  // Present one operand pair, then wait for the result and check latency/value.
  task automatic start_op(input logic [31:0] a, input logic [31:0] g, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    act = a; grad = g; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; act = $urandom; grad = $urandom;
    n = 1;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, n, LAT);
    check(tag, o, ref_o(a, g));
  endtask

  task automatic finish_op(input string tag);
    logic [31:0] held;
    held = o;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_keep"}, o, held);
  endtask

  initial begin
    logic [31:0] a, g, exp;
    int hold;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; act = '0; grad = '0;
    #12;
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    check("rst_o", o, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    start_op(32'h00800000, 32'h01000000, "half");
    check("half_const", o, 32'h00400000);
    finish_op("half");
    start_op(32'h00999999, 32'hFF000000, "neg1");
    check("neg1_const", o, 32'hFFC28F5D);
    finish_op("neg1");
    start_op(32'hFF000000, 32'h01000000, "clamp_lo");
    check("clamp_lo_const", o, 32'h0);
    finish_op("clamp_lo");
    start_op(32'h02000000, 32'h7FFFFFFF, "clamp_hi");
    check("clamp_hi_const", o, 32'h0);
    finish_op("clamp_hi");
    start_op(32'h00800000, 32'h80000000, "gmin");
    check("gmin_const", o, 32'hE0000000);
    finish_op("gmin");
    start_op(32'h00800000, 32'h7FFFFFFF, "gmax");
    check("gmax_const", o, 32'h1FFFFFFF);
    finish_op("gmax");
    start_op(32'h00400000, 32'h0, "gzero");
    finish_op("gzero");
    start_op(32'h01000000, 32'hC0000000, "act_one");
    finish_op("act_one");

    // Backpressure with an ignored input pulse.
    start_op(32'h00600000, 32'hFE800000, "bp");
    exp = ref_o(32'h00600000, 32'hFE800000);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin act = 32'h00800000; grad = 32'h01000000; in_valid = 1'b1; end
      if (i == 7) in_valid = 1'b0;
      @(posedge clk); #1;
      check("bp_o", o, exp);
      check("bp_vld", {31'd0, out_valid}, 32'd1);
      check("bp_rdy", {31'd0, in_ready}, 32'd0);
    end
    finish_op("bp");
    @(posedge clk); #1;
    check("bp_idle", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset during the second multiply pass.
    act = 32'h00800000; grad = 32'h01000000; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_vld", {31'd0, out_valid}, 32'd0);
    check("arst_o", o, 32'd0);
    check("arst_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    start_op(32'h00333333, 32'h05000000, "post_rst");
    finish_op("post_rst");

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 32'h01000000);
        1: a = $urandom;
        2: a = 32'h01000000 - $urandom_range(0, 255);
        default: a = $urandom_range(0, 255);
      endcase
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 32'h00FFFFFF) : $urandom;
      start_op(a, g, "rand");
      exp = ref_o(a, g);
      hold = $urandom_range(0, 3);
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check("rand_hold", o, exp);
      end
      finish_op("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sigmf_bwd.md
Name: sigmf_bwd

Overview:
Backward-pass counterpart of the forward sigmoid activation in the LSTM datapath. It takes a stored forward sigmoid output s and an upstream gradient g, and returns o = g * s * (1 - s), the gradient propagated back through the sigmoid. All values are signed fixed-point Q8.24, where 0x01000000 = 1.0, matching the forward unit. The multiplier is iterative shift-add, with a valid/ready handshake on both sides, and it sits between the backprop delta path and the gate-gradient accumulators.

Parameters:
WIDTH, 32, data word width in bits (two's complement).
FRAC, 24, number of fractional bits (1.0 = 1 << FRAC).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  act/grad are valid this cycle.
in_ready  output  1  block can accept a new operand pair.
act  input  WIDTH  forward sigmoid output s, Q8.24.
grad  input  WIDTH  upstream gradient g, Q8.24.
out_valid  output  1  o holds a finished result.
out_ready  input  1  consumer accepts o this cycle.
o  output  WIDTH  propagated gradient g*s*(1-s), Q8.24.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; o = 0; out_valid = 0; in_ready = 1; counter and shift registers cleared.
  - Reset asserted in any state aborts the in-flight operation and discards its result.
- in_ready = 1 only in IDLE; it is decoded from state with no extra latency. out_valid = 1 only in DONE.
- States:
  - IDLE: on in_valid && in_ready, latch operands and go to MUL1 with cnt = 0.
    - act clamps at latch: act < 0 becomes 0; act > 0x01000000 becomes 0x01000000.
    - Latched registers: sa = clamped act; ca = (1 << FRAC) - sa; mag_g = |grad|; sgn = grad[WIDTH-1].
    - in_valid without acceptance (any other state) is ignored. No queuing.
  - MUL1: unsigned shift-add of sa * ca, one multiplier bit per cycle, WIDTH cycles (cnt 0..WIDTH-1). On the last cycle, d = product >> FRAC (truncate), then go to MUL2 with cnt = 0.
  - MUL2: unsigned shift-add of d * mag_g, WIDTH cycles. On the last cycle, m = product >> FRAC (truncate), and o is registered as sgn ? -m : m. Then go to DONE.
  - DONE: out_valid = 1, o held stable. On out_ready, go to IDLE; out_valid falls and in_ready rises on the next cycle. o keeps its last value until the next result is written.
- Latency: accept edge to out_valid high is exactly 2*WIDTH + 1 cycles (65 at default). Throughput is one result per 2*WIDTH + 2 cycles when out_ready is held high.
- Arithmetic and width rules:
  - Partial-product accumulator is 2*WIDTH bits wide.
  - d ≤ 0x00400000 (0.25), so |o| ≤ |grad|/4 and no overflow or saturation is possible.
  - grad = 0x80000000: |grad| = 2^31 is held unsigned, giving o = 0xE0000000 when s = 0.5.
  - Rounding is truncation of the magnitude, i.e. toward zero.
- Boundaries:
  - act = 0 or act = 1.0 gives o = 0 for any grad.
  - grad = 0 gives o = 0; the sign of zero is irrelevant.
- out_ready held low: o and out_valid are stable indefinitely, and in_ready stays 0.

Test Plan:
1. Reset, then act = 0x00800000, grad = 0x01000000 -> o = 0x00400000, out_valid rises exactly 65 cycles after the accept edge.
2. act = 0x00999999, grad = 0xFF000000 (-1.0) -> intermediate d = 0x003D70A3, o = 0xFFC28F5D.
3. Clamping: act = 0xFF000000 -> o = 0x00000000. act = 0x02000000, grad = 0x7FFFFFFF -> o = 0x00000000.
4. Extreme grad: act = 0x00800000, grad = 0x80000000 -> o = 0xE0000000. Same act with grad = 0x7FFFFFFF -> o = 0x1FFFFFFF.
5. Backpressure and overlap, with out_ready = 0 for 20 cycles after out_valid and a new in_valid pulsed meanwhile:
   - o and out_valid stay stable throughout; in_ready stays 0 and the pulse is not accepted.
   - Raising out_ready gives in_ready = 1 on the following cycle.
6. Reset mid-operation: assert rst during MUL2 -> same cycle (asynchronous): out_valid = 0, o = 0, in_ready = 1. The next operand pair completes normally with the correct value.
